// File: rtl/w80386_bus_arbiter.sv
// Two-master arbiter for the core memory bus: prefetch (m0) and data unit (m1), one
// transaction at a time with a watchdog. W80386_BUS_ARBITER_ROUND_ROBIN_EN selects alternation.
module w80386_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  m0_vaild,
    input  logic                  m0_write_enable,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0] m0_write_data,
    output logic                  m0_ready,
    output logic [DATA_WIDTH-1:0] m0_read_data,
    output logic                  m0_error,

    input  logic                  m1_vaild,
    input  logic                  m1_write_enable,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0] m1_write_data,
    output logic                  m1_ready,
    output logic [DATA_WIDTH-1:0] m1_read_data,
    output logic                  m1_error,

    output logic                  bus_vaild,
    input  logic                  bus_ready,
    output logic                  bus_write_enable,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic [DATA_WIDTH-1:0] bus_write_data,
    input  logic [DATA_WIDTH-1:0] bus_read_data,

    output logic                  grant_owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] TERM_CNT = 16'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  grant_q, grant_d;
    logic                  bus_vaild_q, bus_vaild_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic                  m0_ready_q, m0_ready_d;
    logic                  m1_ready_q, m1_ready_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic                  m0_err_q, m0_err_d;
    logic                  m1_err_q, m1_err_d;

    logic any_req;
    logic winner;
    logic timeout_hit;
    logic done;

    assign any_req = m0_vaild | m1_vaild;

`ifdef W80386_BUS_ARBITER_ROUND_ROBIN_EN
    // A tie goes to whoever did not own the bus last, so neither master starves.
    assign winner = (m0_vaild && m1_vaild) ? ~grant_q : m1_vaild;
`else
    // Data unit beats prefetch on a tie; prefetch may starve under sustained m1 traffic.
    assign winner = m1_vaild;
`endif

    // A bus_ready on the terminal count still completes normally.
    assign timeout_hit = (cnt_q == TERM_CNT) && !bus_ready;
    assign done        = bus_ready || timeout_hit;

    // NOTE: every register updates with <= so all _q values change together at the edge,
    // and the asynchronous reset drops any in-flight transaction without a ready pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grant_q     <= 1'b0;
            bus_vaild_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            m0_ready_q  <= 1'b0;
            m1_ready_q  <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            bus_vaild_q <= bus_vaild_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            m0_ready_q  <= m0_ready_d;
            m1_ready_q  <= m1_ready_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_err_q    <= m0_err_d;
            m1_err_q    <= m1_err_d;
        end
    end

    // NOTE: each combinational block assigns every output a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUS;
            BUS:     if (done)    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        bus_vaild_d = bus_vaild_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        m0_ready_d  = 1'b0;
        m1_ready_d  = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        m0_err_d    = 1'b0;
        m1_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (any_req) begin
                    grant_d     = winner;
                    bus_vaild_d = 1'b1;
                    bus_we_d    = winner ? m1_write_enable : m0_write_enable;
                    bus_addr_d  = winner ? m1_address      : m0_address;
                    bus_wdata_d = winner ? m1_write_data   : m0_write_data;
                end
            end
            BUS: begin
                if (done) begin
                    bus_vaild_d = 1'b0;
                    // Ready, data and error are loaded here so they appear during RESP.
                    if (grant_q) begin
                        m1_ready_d = 1'b1;
                        m1_rdata_d = bus_ready ? bus_read_data : '1;
                        m1_err_d   = ~bus_ready;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_rdata_d = bus_ready ? bus_read_data : '1;
                        m0_err_d   = ~bus_ready;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign m0_ready         = m0_ready_q;
    assign m0_read_data     = m0_rdata_q;
    assign m0_error         = m0_err_q;
    assign m1_ready         = m1_ready_q;
    assign m1_read_data     = m1_rdata_q;
    assign m1_error         = m1_err_q;
    assign bus_vaild        = bus_vaild_q;
    assign bus_write_enable = bus_we_q;
    assign bus_address      = bus_addr_q;
    assign bus_write_data   = bus_wdata_q;
    assign grant_owner      = grant_q;

endmodule

// File: tb/tb_w80386_bus_arbiter.sv
// Bench for w80386_bus_arbiter: two instances (default watchdog and a 4-cycle watchdog)
// driven by shared stimulus, checked against a transaction-level arbitration model.
module tb_w80386_bus_arbiter;

    localparam int T_A = 255;
    localparam int T_B = 4;

    typedef enum int {KEEP, DROP, RENEW} after_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  rv;
    logic [1:0]  rwe;
    logic [31:0] ra  [2];
    logic [31:0] rwd [2];
    logic        bus_ready;
    logic [31:0] bus_read_data;

    logic        a_m0_ready, a_m0_err, a_m1_ready, a_m1_err;
    logic [31:0] a_m0_rd, a_m1_rd;
    logic        a_bv, a_bwe, a_grant;
    logic [31:0] a_ba, a_bwd;
    logic        b_m0_ready, b_m0_err, b_m1_ready, b_m1_err;
    logic [31:0] b_m0_rd, b_m1_rd;
    logic        b_bv, b_bwe, b_grant;
    logic [31:0] b_ba, b_bwd;

    logic        sel_b;
    logic        obs_bv, obs_bwe, obs_grant;
    logic [31:0] obs_ba, obs_bwd;
    logic        obs_ready [2];
    logic        obs_err   [2];
    logic [31:0] obs_rd    [2];

    // Reference model state
    logic        exp_owner;
    logic [31:0] last_rd [2];

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    w80386_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T_A)) dut_a (
        .clock(clock), .reset(reset),
        .m0_vaild(rv[0]), .m0_write_enable(rwe[0]), .m0_address(ra[0]), .m0_write_data(rwd[0]),
        .m0_ready(a_m0_ready), .m0_read_data(a_m0_rd), .m0_error(a_m0_err),
        .m1_vaild(rv[1]), .m1_write_enable(rwe[1]), .m1_address(ra[1]), .m1_write_data(rwd[1]),
        .m1_ready(a_m1_ready), .m1_read_data(a_m1_rd), .m1_error(a_m1_err),
        .bus_vaild(a_bv), .bus_ready(bus_ready), .bus_write_enable(a_bwe),
        .bus_address(a_ba), .bus_write_data(a_bwd), .bus_read_data(bus_read_data),
        .grant_owner(a_grant)
    );

    w80386_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T_B)) dut_b (
        .clock(clock), .reset(reset),
        .m0_vaild(rv[0]), .m0_write_enable(rwe[0]), .m0_address(ra[0]), .m0_write_data(rwd[0]),
        .m0_ready(b_m0_ready), .m0_read_data(b_m0_rd), .m0_error(b_m0_err),
        .m1_vaild(rv[1]), .m1_write_enable(rwe[1]), .m1_address(ra[1]), .m1_write_data(rwd[1]),
        .m1_ready(b_m1_ready), .m1_read_data(b_m1_rd), .m1_error(b_m1_err),
        .bus_vaild(b_bv), .bus_ready(bus_ready), .bus_write_enable(b_bwe),
        .bus_address(b_ba), .bus_write_data(b_bwd), .bus_read_data(bus_read_data),
        .grant_owner(b_grant)
    );

    always_comb begin
        obs_bv       = sel_b ? b_bv       : a_bv;
        obs_bwe      = sel_b ? b_bwe      : a_bwe;
        obs_ba       = sel_b ? b_ba       : a_ba;
        obs_bwd      = sel_b ? b_bwd      : a_bwd;
        obs_grant    = sel_b ? b_grant    : a_grant;
        obs_ready[0] = sel_b ? b_m0_ready : a_m0_ready;
        obs_ready[1] = sel_b ? b_m1_ready : a_m1_ready;
        obs_err[0]   = sel_b ? b_m0_err   : a_m0_err;
        obs_err[1]   = sel_b ? b_m1_err   : a_m1_err;
        obs_rd[0]    = sel_b ? b_m0_rd    : a_m0_rd;
        obs_rd[1]    = sel_b ? b_m1_rd    : a_m1_rd;
    end

    task automatic new_req(input int i);
        rv[i]  = 1'b1;
        rwe[i] = 1'($urandom_range(0, 1));
        ra[i]  = $urandom;
        rwd[i] = $urandom;
    endtask

    // Resets both instances, checks every output is zero, and releases at a negedge.
    task automatic do_reset();
        logic [134:0] got;
        rv = 2'b00;
        rwe = 2'b00;
        bus_ready = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        got = {a_bv, a_bwe, a_ba, a_bwd, a_grant, a_m0_ready, a_m0_rd, a_m0_err,
               a_m1_ready, a_m1_rd, a_m1_err};
        checks++;
        if (got !== '0) $display("FAIL reset_a: got %h want 0", got); else passed++;
        got = {b_bv, b_bwe, b_ba, b_bwd, b_grant, b_m0_ready, b_m0_rd, b_m0_err,
               b_m1_ready, b_m1_rd, b_m1_err};
        checks++;
        if (got !== '0) $display("FAIL reset_b: got %h want 0", got); else passed++;
        reset = 1'b1;
        exp_owner = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    // One whole transaction on the selected instance. Entered and left at a negedge in IDLE.
    // waits = idle BUS cycles before bus_ready; waits >= timeout means the watchdog fires.
    task automatic txn(input int waits, input logic [31:0] rdata, input after_t after,
                       output logic win);
        int          tmo, nb, wi, oi;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [66:0] exp_bus, got_bus;
        tmo = sel_b ? T_B : T_A;
`ifdef W80386_BUS_ARBITER_ROUND_ROBIN_EN
        win = (rv[0] && rv[1]) ? ~exp_owner : rv[1];
`else
        win = rv[1];
`endif
        wi = int'(win);
        oi = 1 - wi;
        exp_bus = {1'b1, rwe[wi], ra[wi], rwd[wi], win};
        exp_err = (waits >= tmo);
        nb      = exp_err ? tmo : waits + 1;
        exp_rd  = exp_err ? 32'hFFFF_FFFF : rdata;
        for (int c = 0; c < nb; c++) begin
            @(negedge clock);
            got_bus = {obs_bv, obs_bwe, obs_ba, obs_bwd, obs_grant};
            checks++;
            if (got_bus !== exp_bus)
                $display("FAIL bus_req c%0d: got %h want %h", c, got_bus, exp_bus);
            else passed++;
            checks++;
            if ({obs_ready[1], obs_ready[0]} !== 2'b00)
                $display("FAIL early_ready c%0d: got %b want 00", c, {obs_ready[1], obs_ready[0]});
            else passed++;
            bus_ready     = (c == waits);
            bus_read_data = (c == waits) ? rdata : $urandom;
            // Fields changing after the grant must not reach the bus.
            if (c == 0) begin
                ra[wi]  = ~ra[wi];
                rwd[wi] = $urandom;
            end
        end
        @(negedge clock);
        bus_ready = 1'($urandom_range(0, 1));
        checks++;
        if (obs_bv !== 1'b0) $display("FAIL resp_vaild: got %b want 0", obs_bv); else passed++;
        checks++;
        if ({obs_ready[1], obs_ready[0]} !== (win ? 2'b10 : 2'b01))
            $display("FAIL resp_ready: got %b want owner %0d", {obs_ready[1], obs_ready[0]}, wi);
        else passed++;
        checks++;
        if (obs_rd[wi] !== exp_rd) $display("FAIL resp_data: got %h want %h", obs_rd[wi], exp_rd);
        else passed++;
        checks++;
        if (obs_err[wi] !== exp_err) $display("FAIL resp_error: got %b want %b", obs_err[wi], exp_err);
        else passed++;
        checks++;
        if ({obs_err[oi], obs_rd[oi]} !== {1'b0, last_rd[oi]})
            $display("FAIL other_hold: got %h want %h", {obs_err[oi], obs_rd[oi]}, {1'b0, last_rd[oi]});
        else passed++;
        last_rd[wi] = exp_rd;
        exp_owner = win;
        case (after)
            DROP:    rv[wi] = 1'b0;
            RENEW: begin
                new_req(wi);
                rv[wi] = 1'($urandom_range(0, 1));
            end
            default: ;
        endcase
        @(negedge clock);
        checks++;
        if ({obs_bv, obs_ready[1], obs_ready[0], obs_err[1], obs_err[0], obs_grant} !== {5'b0, win})
            $display("FAIL idle_after: got %b want %b",
                     {obs_bv, obs_ready[1], obs_ready[0], obs_err[1], obs_err[0], obs_grant}, {5'b0, win});
        else passed++;
        checks++;
        if ({obs_rd[1], obs_rd[0]} !== {last_rd[1], last_rd[0]})
            $display("FAIL idle_hold: got %h want %h", {obs_rd[1], obs_rd[0]}, {last_rd[1], last_rd[0]});
        else passed++;
    endtask

    task automatic test_reset();
        sel_b = 1'b0;
        do_reset();
    endtask

    task automatic test_single_read();
        logic w;
        do_reset();
        sel_b = 1'b0;
        rv[0] = 1'b1; rwe[0] = 1'b0; ra[0] = 32'h0000_FFF0; rwd[0] = 32'h0;
        txn(0, 32'hEA00_F000, DROP, w);
        checks++;
        if (w !== 1'b0) $display("FAIL single_owner: got %b want 0", w); else passed++;
        checks++;
        if (obs_rd[0] !== 32'hEA00_F000) $display("FAIL single_data: got %h want EA00F000", obs_rd[0]);
        else passed++;
    endtask

    task automatic test_simultaneous();
        logic w;
        logic [3:0] order;
        do_reset();
        sel_b = 1'b0;
        rv = 2'b11;
        rwe[0] = 1'b0; ra[0] = 32'h0000_0100; rwd[0] = 32'h0;
        rwe[1] = 1'b1; ra[1] = 32'h0000_0200; rwd[1] = 32'hDEAD_BEEF;
`ifdef W80386_BUS_ARBITER_ROUND_ROBIN_EN
        txn(0, $urandom, KEEP, w); order[0] = w;
        txn(1, $urandom, KEEP, w); order[1] = w;
        txn(0, $urandom, KEEP, w); order[2] = w;
        txn(2, $urandom, DROP, w); order[3] = w;
        checks++;
        if (order !== 4'b0101) $display("FAIL rr_order: got %b want 0101 (lsb first)", order);
        else passed++;
`else
        txn(0, $urandom, KEEP, w); order[0] = w;
        txn(1, $urandom, DROP, w); order[1] = w;
        txn(0, $urandom, DROP, w); order[2] = w;
        order[3] = 1'b0;
        checks++;
        if (order !== 4'b0011) $display("FAIL prio_order: got %b want 0011 (lsb first)", order);
        else passed++;
`endif
    endtask

    task automatic test_wait_states();
        logic w;
        do_reset();
        sel_b = 1'b0;
        new_req(1);
        txn(5, $urandom, DROP, w);
        new_req(0);
        txn(3, $urandom, DROP, w);
    endtask

    task automatic test_timeout();
        logic w;
        do_reset();
        sel_b = 1'b1;
        rv[0] = 1'b1; rwe[0] = 1'b0; ra[0] = $urandom; rwd[0] = 32'h0;
        txn(20, $urandom, KEEP, w);
        checks++;
        if (last_rd[0] !== 32'hFFFF_FFFF) $display("FAIL timeout_data: got %h want FFFFFFFF", b_m0_rd);
        else passed++;
        // A second abort must take the full count again, proving the counter cleared.
        txn(T_B, $urandom, DROP, w);
    endtask

    task automatic test_timeout_tie();
        logic w;
        do_reset();
        sel_b = 1'b1;
        rv[0] = 1'b1; rwe[0] = 1'b0; ra[0] = $urandom; rwd[0] = 32'h0;
        txn(T_B - 1, 32'h1234_5678, DROP, w);
        new_req(1);
        txn(T_B - 1, $urandom, DROP, w);
    endtask

    task automatic test_random(input logic use_b, input int iters);
        logic w;
        do_reset();
        sel_b = use_b;
        for (int i = 0; i < iters; i++) begin
            if (rv == 2'b00) begin
                bus_ready = 1'($urandom_range(0, 1));
                @(negedge clock);
                checks++;
                if ({obs_bv, obs_ready[1], obs_ready[0]} !== 3'b000)
                    $display("FAIL idle_quiet: got %b want 000", {obs_bv, obs_ready[1], obs_ready[0]});
                else passed++;
                case ($urandom_range(0, 2))
                    0: new_req(0);
                    1: new_req(1);
                    default: begin new_req(0); new_req(1); end
                endcase
            end else begin
                txn($urandom_range(0, 6), $urandom, RENEW, w);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic w;
        do_reset();
        sel_b = 1'b0;
        new_req(1);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({obs_bv, obs_grant} !== 2'b11) $display("FAIL pre_reset: got %b want 11", {obs_bv, obs_grant});
        else passed++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({obs_bv, obs_grant} !== 2'b00) $display("FAIL async_reset: got %b want 00", {obs_bv, obs_grant});
        else passed++;
        rv = 2'b00;
        bus_ready = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        exp_owner = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if ({obs_bv, obs_ready[1], obs_ready[0], obs_grant} !== 4'b0000)
                $display("FAIL post_reset c%0d: got %b want 0000", c,
                         {obs_bv, obs_ready[1], obs_ready[0], obs_grant});
            else passed++;
        end
        new_req(0);
        txn(1, $urandom, DROP, w);
        checks++;
        if (w !== 1'b0) $display("FAIL post_reset_owner: got %b want 0", w); else passed++;
    endtask

    initial begin
        reset = 1'b0;
        rv = 2'b00; rwe = 2'b00;
        ra[0] = '0; ra[1] = '0; rwd[0] = '0; rwd[1] = '0;
        bus_ready = 1'b0;
        bus_read_data = '0;
        sel_b = 1'b0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_wait_states();
        test_timeout();
        test_timeout_tie();
        test_random(1'b0, 40);
        test_random(1'b1, 40);
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
